data_mem: RTL and testbench

DATA_MEM -- requirements
Module: data_mem

---
 rtl/data_mem.sv | 134 +++++++++++++
 tb/tb_data_mem.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/data_mem.sv
// Single-port word/byte data memory with a two-state valid/yumi handshake.
// Each accepted request produces exactly one response that is held until the requester consumes it.
module data_mem #(
    parameter int ADDR_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [35:0] port_flat_i,
    input  logic [31:0] addr,
    output logic [33:0] port_flat_o
);

    localparam int IDX_W = (ADDR_WORDS > 1) ? $clog2(ADDR_WORDS) : 1;
    localparam logic [32:0] BYTE_CAP = 33'(4 * ADDR_WORDS);

    typedef enum logic {
        S_IDLE,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic             w_in_valid;
    logic             w_in_wen;
    logic             w_in_byte;
    logic [31:0]      w_in_wdata;
    logic             w_in_yumi;
    logic             w_in_range;
    logic [IDX_W-1:0] w_idx;
    logic [1:0]       w_lane;
    logic             w_accept;
    logic             w_out_valid;
    logic             w_out_yumi;
    logic [31:0]      w_rd_word;
    logic [7:0]       w_rd_byte;
    logic [31:0]      w_read_data;

    logic             r_zero;
    logic             r_byte;
    logic [1:0]       r_lane;

    assign w_in_valid = port_flat_i[35];
    assign w_in_wen   = port_flat_i[34];
    assign w_in_byte  = port_flat_i[33];
    assign w_in_wdata = port_flat_i[32:1];
    assign w_in_yumi  = port_flat_i[0];

    assign w_in_range = ({1'b0, addr} < BYTE_CAP);
    assign w_idx      = addr[IDX_W+1:2];
    assign w_lane     = addr[1:0];

    // Requests arriving during reset are neither acknowledged nor executed.
    assign w_accept   = (r_state == S_IDLE) && w_in_valid && !reset;
    assign w_out_yumi = w_accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = S_RESP;
            S_RESP: if (w_in_yumi) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Writes and out-of-range accesses answer with zero data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_zero <= 1'b1;
            r_byte <= 1'b0;
            r_lane <= 2'd0;
        end else if (w_accept) begin
            r_zero <= w_in_wen || !w_in_range;
            r_byte <= w_in_byte;
            r_lane <= w_lane;
        end
    end

    // One byte-wide RAM per lane so byte writes map onto byte-enabled block RAM.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [ADDR_WORDS];
            logic [7:0] r_rd;
            logic       w_we;
            logic [7:0] w_wbyte;

            assign w_we    = w_accept && w_in_wen && w_in_range &&
                             (!w_in_byte || (w_lane == 2'(gi)));
            assign w_wbyte = w_in_byte ? w_in_wdata[7:0] : w_in_wdata[8*gi +: 8];

            always_ff @(posedge clk) begin
                if (w_we) begin
                    r_mem[w_idx] <= w_wbyte;
                end
                if (w_accept && !w_in_wen) begin
                    r_rd <= r_mem[w_idx];
                end
            end

            assign w_rd_word[8*gi +: 8] = r_rd;
        end
    endgenerate

    always_comb begin
        w_rd_byte = w_rd_word[7:0];
        case (r_lane)
            2'd0: w_rd_byte = w_rd_word[7:0];
            2'd1: w_rd_byte = w_rd_word[15:8];
            2'd2: w_rd_byte = w_rd_word[23:16];
            2'd3: w_rd_byte = w_rd_word[31:24];
            default: w_rd_byte = w_rd_word[7:0];
        endcase
    end

    assign w_out_valid = (r_state == S_RESP) && !reset;

    always_comb begin
        w_read_data = 32'd0;
        if (w_out_valid && !r_zero) begin
            w_read_data = r_byte ? {24'd0, w_rd_byte} : w_rd_word;
        end
    end

    assign port_flat_o = {w_out_valid, w_read_data, w_out_yumi};

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: handshake timing, word/byte access, range limits and reset behaviour.
module tb_data_mem;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [33:0] port_flat_o;

    logic        in_valid;
    logic        in_wen;
    logic        in_byte;
    logic [31:0] in_wdata;
    logic        in_yumi;

    logic        o_valid;
    logic [31:0] o_rdata;
    logic        o_yumi;

    int checks;
    int passed;

    data_mem #(.ADDR_WORDS(1024)) dut (
        .clk        (clk),
        .reset      (reset),
        .port_flat_i({in_valid, in_wen, in_byte, in_wdata, in_yumi}),
        .addr       (addr),
        .port_flat_o(port_flat_o)
    );

    assign o_valid = port_flat_o[33];
    assign o_rdata = port_flat_o[32:1];
    assign o_yumi  = port_flat_o[0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Called #1 after a rising edge with the DUT idle; returns #1 after the edge that ends the response.
    task automatic req(input string tag, input logic wen, input logic bnw,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp);
        in_valid = 1'b1; in_wen = wen; in_byte = bnw; addr = a; in_wdata = wd; in_yumi = 1'b1;
        #1;
        check({tag, " accept_yumi"}, {31'd0, o_yumi}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        check({tag, " resp_valid"}, {31'd0, o_valid}, 32'd1);
        check({tag, " resp_data"}, o_rdata, exp);
        @(posedge clk); #1;
        $display("txn %s wen=%0b byte=%0b addr=%h wdata=%h exp=%h", tag, wen, bnw, a, wd, exp);
    endtask

    initial begin
        int accepts;
        int resps;
        logic [31:0] held;
        checks = 0; passed = 0;
        reset = 1'b1; in_valid = 1'b0; in_wen = 1'b0; in_byte = 1'b0;
        in_wdata = 32'd0; in_yumi = 1'b0; addr = 32'd0;
        repeat (2) @(posedge clk);
        #2;
        check("reset valid", {31'd0, o_valid}, 32'd0);
        check("reset yumi", {31'd0, o_yumi}, 32'd0);
        check("reset data", o_rdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        in_yumi = 1'b1; #1;
        check("idle yumi ignored", {31'd0, o_valid}, 32'd0);
        @(posedge clk); #1;
        check("idle stays idle", {31'd0, o_valid}, 32'd0);

        req("w_wr10", 1'b1, 1'b0, 32'h10, 32'hA5A5_1234, 32'd0);
        req("w_rd10", 1'b0, 1'b0, 32'h10, 32'h0, 32'hA5A5_1234);
        req("w_wr20", 1'b1, 1'b0, 32'h20, 32'h1122_3344, 32'd0);
        req("b_wr21", 1'b1, 1'b1, 32'h21, 32'hABCD_EFFF, 32'd0);
        req("w_rd20", 1'b0, 1'b0, 32'h20, 32'h0, 32'h1122_FF44);
        req("b_rd23", 1'b0, 1'b1, 32'h23, 32'h0, 32'h0000_0011);
        req("b_rd20", 1'b0, 1'b1, 32'h20, 32'h0, 32'h0000_0044);
        req("w_wr33", 1'b1, 1'b0, 32'h33, 32'h0000_0055, 32'd0);
        req("w_rd30", 1'b0, 1'b0, 32'h30, 32'h0, 32'h0000_0055);

        // Back-to-back fill with valid and yumi held high, address changed every two cycles.
        accepts = 0; resps = 0;
        in_valid = 1'b1; in_wen = 1'b1; in_byte = 1'b0; in_yumi = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            addr = 32'(i * 4); in_wdata = 32'(i);
            #1;
            if (o_yumi) accepts++;
            @(posedge clk); #2;
            if (o_valid && !o_yumi) resps++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("fill accepts", 32'(accepts), 32'd1024);
        check("fill resps", 32'(resps), 32'd1024);
        $display("txn fill 1024 words accepts=%0d resps=%0d", accepts, resps);

        req("rd_ffc", 1'b0, 1'b0, 32'hFFC, 32'h0, 32'h0000_03FF);
        req("rd_000", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        req("oor_wr", 1'b1, 1'b0, 32'hDEAD_DEAD, 32'h1, 32'd0);
        req("oor_chk0", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        req("oor_chkffc", 1'b0, 1'b0, 32'hFFC, 32'h0, 32'h0000_03FF);
        req("oor_rd", 1'b0, 1'b0, 32'hDEAD_DEAD, 32'h0, 32'd0);
        req("edge_wr1000", 1'b1, 1'b0, 32'h1000, 32'h77, 32'd0);
        req("edge_rd1000", 1'b0, 1'b0, 32'h1000, 32'h0, 32'd0);
        req("edge_rd000", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        req("w_wr40", 1'b1, 1'b0, 32'h40, 32'h1234_5678, 32'd0);

        // Response held for three cycles while a new request waits.
        in_valid = 1'b1; in_wen = 1'b0; in_byte = 1'b0; addr = 32'h40; in_yumi = 1'b0;
        @(posedge clk); #1;
        in_wen = 1'b1; addr = 32'h44; in_wdata = 32'hEE;
        held = 32'h1234_5678;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("hold valid", {31'd0, o_valid}, 32'd1);
            check("hold data", o_rdata, held);
            check("hold yumi", {31'd0, o_yumi}, 32'd0);
            @(posedge clk); #1;
        end
        in_yumi = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; #1;
        check("hold release", {31'd0, o_valid}, 32'd0);
        $display("txn hold read addr=00000040 data=%h", held);
        @(posedge clk); #1;
        req("rd_44", 1'b0, 1'b0, 32'h44, 32'h0, 32'h0000_0011);

        // Reset while a response is pending, with a write presented in the reset cycle.
        in_valid = 1'b1; in_wen = 1'b0; addr = 32'h40; in_yumi = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; in_wen = 1'b1; in_wdata = 32'hBAD; #1;
        check("rst yumi", {31'd0, o_yumi}, 32'd0);
        @(posedge clk); #2;
        check("rst valid", {31'd0, o_valid}, 32'd0);
        check("rst data", o_rdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        #1;
        check("post rst valid", {31'd0, o_valid}, 32'd0);
        $display("txn reset during resp");
        req("rd_40", 1'b0, 1'b0, 32'h40, 32'h0, 32'h1234_5678);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
